// File: rtl/ddr_pwrup_seq.sv
// ddr_pwrup_seq: DDR3 RESET_N/CKE power-up sequencer (ports: clk, rst, start, cke_en -> ddr_rst_n, ddr_cke, busy, done)
module ddr_pwrup_seq #(
  parameter int RST_CYCLES  = 80000,
  parameter int CKE_CYCLES  = 200000,
  parameter int TXPR_CYCLES = 128,
  parameter int CNT_WIDTH   = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic cke_en,
  output logic ddr_rst_n,
  output logic ddr_cke,
  output logic busy,
  output logic done
);
  typedef enum logic [2:0] {IDLE, HOLD_RST, HOLD_CKE, TXPR, READY} state_t;
  localparam logic [CNT_WIDTH-1:0] RST_LD  = CNT_WIDTH'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CKE_LD  = CNT_WIDTH'(CKE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TXPR_LD = CNT_WIDTH'(TXPR_CYCLES - 1);
  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic rst_n_q, rst_n_d, cke_q, cke_d, busy_q, busy_d, done_q, done_d;
  logic zero;
  always_comb begin
    zero    = cnt_q == '0;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, READY: if (start) begin
        state_d = HOLD_RST;
        cnt_d   = RST_LD;
      end
      HOLD_RST: begin
        state_d = zero ? HOLD_CKE : HOLD_RST;
        cnt_d   = zero ? CKE_LD : cnt_q - 1'b1;
      end
      HOLD_CKE: begin
        state_d = zero ? TXPR : HOLD_CKE;
        cnt_d   = zero ? TXPR_LD : cnt_q - 1'b1;
      end
      TXPR: begin
        state_d = zero ? READY : TXPR;
        cnt_d   = zero ? '0 : cnt_q - 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    rst_n_d = state_d inside {HOLD_CKE, TXPR, READY};
    busy_d  = state_d inside {HOLD_RST, HOLD_CKE, TXPR};
    done_d  = state_d == READY;
    // CKE follows cke_en only once already in READY; the entry cycle keeps it high
    cke_d   = state_d == TXPR || (state_d == READY && (state_q != READY || cke_en));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rst_n_q <= 1'b0;
      cke_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
      cke_q   <= cke_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  assign ddr_rst_n = rst_n_q;
  assign ddr_cke   = cke_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule
